// File: rtl/output_allocator.sv
// Two-way round-robin output allocator with packet-granular grants,
// stall watchdog and per-input packet counters.
module output_allocator #(
    parameter int WIDTH   = 11,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             ready_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             ready_b,
    input  logic             out_full,
    output logic             out_write,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] pkt_cnt_a,
    output logic [CNT_W-1:0] pkt_cnt_b,
    output logic             err_timeout
);

    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t     state, state_nx;
    logic       prio, prio_nx;
    logic [7:0] stall, stall_nx;
    logic       err_nx;
    logic       xfer_a, xfer_b;
    logic       inc_a, inc_b;

    assign ready_a   = (state == GRANT_A) & ~out_full;
    assign ready_b   = (state == GRANT_B) & ~out_full;
    assign xfer_a    = req_a & ready_a;
    assign xfer_b    = req_b & ready_b;
    assign out_write = xfer_a | xfer_b;
    assign out_data  = (state == GRANT_A) ? data_a :
                       (state == GRANT_B) ? data_b : '0;

    always_comb begin
        state_nx = state;
        prio_nx  = prio;
        stall_nx = stall;
        err_nx   = err_timeout;
        inc_a    = 1'b0;
        inc_b    = 1'b0;
        unique case (state)
            IDLE: begin
                stall_nx = '0;
                if (req_a && (!req_b || !prio))
                    state_nx = GRANT_A;
                else if (req_b)
                    state_nx = GRANT_B;
            end
            GRANT_A: begin
                if (xfer_a && data_a[WIDTH-1]) begin
                    // releasing A: B wins if it asks, else A may keep going
                    inc_a    = 1'b1;
                    prio_nx  = 1'b1;
                    stall_nx = '0;
                    state_nx = req_b ? GRANT_B :
                               req_a ? GRANT_A : IDLE;
                end else if (req_a) begin
                    stall_nx = '0;
                end else if (out_full) begin
                    stall_nx = stall;
                end else if (stall == LIMIT) begin
                    state_nx = IDLE;
                    prio_nx  = 1'b1;
                    err_nx   = 1'b1;
                    stall_nx = '0;
                end else begin
                    stall_nx = stall + 8'd1;
                end
            end
            GRANT_B: begin
                if (xfer_b && data_b[WIDTH-1]) begin
                    inc_b    = 1'b1;
                    prio_nx  = 1'b0;
                    stall_nx = '0;
                    state_nx = req_a ? GRANT_A :
                               req_b ? GRANT_B : IDLE;
                end else if (req_b) begin
                    stall_nx = '0;
                end else if (out_full) begin
                    stall_nx = stall;
                end else if (stall == LIMIT) begin
                    state_nx = IDLE;
                    prio_nx  = 1'b0;
                    err_nx   = 1'b1;
                    stall_nx = '0;
                end else begin
                    stall_nx = stall + 8'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                stall_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            prio        <= 1'b0;
            stall       <= '0;
            err_timeout <= 1'b0;
            pkt_cnt_a   <= '0;
            pkt_cnt_b   <= '0;
        end else begin
            state       <= state_nx;
            prio        <= prio_nx;
            stall       <= stall_nx;
            err_timeout <= err_nx;
            if (inc_a)
                pkt_cnt_a <= pkt_cnt_a + ONE;
            if (inc_b)
                pkt_cnt_b <= pkt_cnt_b + ONE;
        end
    end

endmodule

// File: tb/tb_output_allocator.sv
// Directed checks of the output allocator: grants, backpressure,
// watchdog, asynchronous reset and counter wrap.
module tb_output_allocator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic [10:0] data_a = '0;
    logic [10:0] data_b = '0;
    logic        out_full = 1'b0;
    logic        ready_a, ready_b, out_write, err_timeout;
    logic [10:0] out_data;
    logic [3:0]  pkt_cnt_a, pkt_cnt_b;

    int n_vec = 0;
    int n_bad = 0;

    output_allocator #(.WIDTH(11), .TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .data_a(data_a), .ready_a(ready_a),
        .req_b(req_b), .data_b(data_b), .ready_b(ready_b),
        .out_full(out_full), .out_write(out_write), .out_data(out_data),
        .pkt_cnt_a(pkt_cnt_a), .pkt_cnt_b(pkt_cnt_b),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        data_a = '0;
        data_b = '0;
        out_full = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [10:0] mk(input logic [7:0] base, input int n);
        logic [10:0] f;
        f = 11'(base) | 11'(n);
        if (n % 2 == 1) f = f | 11'h400;
        return f;
    endfunction

    initial begin
        logic [10:0] f1 [3];
        logic [10:0] f3 [4];
        int na, nb, k, owner;
        logic full;
        f1 = '{11'h005, 11'h006, 11'h407};
        f3 = '{11'h011, 11'h012, 11'h013, 11'h414};

        // reset values
        #1;
        check("rst_ready_a", ready_a, 0);
        check("rst_ready_b", ready_b, 0);
        check("rst_write", out_write, 0);
        check("rst_data", out_data, 0);
        check("rst_cnt_a", pkt_cnt_a, 0);
        check("rst_cnt_b", pkt_cnt_b, 0);
        check("rst_err", err_timeout, 0);
        do_reset;

        // single packet
        req_a = 1'b1;
        data_a = f1[0];
        #1;
        check("t1_idle_ready", ready_a, 0);
        check("t1_idle_write", out_write, 0);
        step;
        for (int i = 0; i < 3; i++) begin
            data_a = f1[i];
            #1;
            check("t1_write", out_write, 1);
            check("t1_data", out_data, f1[i]);
            check("t1_ready_a", ready_a, 1);
            check("t1_ready_b", ready_b, 0);
            step;
        end
        #1;
        check("t1_cnt_a", pkt_cnt_a, 1);
        check("t1_ready_b_end", ready_b, 0);
        do_reset;

        // simultaneous requests, alternating 2-flit packets
        na = 0;
        nb = 0;
        req_a = 1'b1;
        req_b = 1'b1;
        data_a = mk(8'hA0, 0);
        data_b = mk(8'hB0, 0);
        #1;
        check("t2_idle_write", out_write, 0);
        step;
        for (int c = 0; c < 8; c++) begin
            owner = (c / 2) % 2;
            data_a = mk(8'hA0, na);
            data_b = mk(8'hB0, nb);
            #1;
            check("t2_write", out_write, 1);
            check("t2_data", out_data,
                  owner == 1 ? mk(8'hB0, nb) : mk(8'hA0, na));
            check("t2_ready_a", ready_a, owner == 0);
            check("t2_ready_b", ready_b, owner == 1);
            if (owner == 1) nb++;
            else na++;
            step;
        end
        #1;
        check("t2_cnt_a", pkt_cnt_a, 2);
        check("t2_cnt_b", pkt_cnt_b, 2);
        do_reset;

        // backpressure for 5 cycles mid-packet
        k = 0;
        req_a = 1'b1;
        data_a = f3[0];
        #1;
        step;
        for (int c = 0; c < 9; c++) begin
            full = (c >= 2 && c <= 6);
            out_full = full;
            data_a = f3[k];
            #1;
            check("t3_write", out_write, !full);
            check("t3_ready_a", ready_a, !full);
            check("t3_err", err_timeout, 0);
            if (!full) begin
                check("t3_data", out_data, f3[k]);
                k++;
            end
            step;
        end
        out_full = 1'b0;
        #1;
        check("t3_flits", k, 4);
        check("t3_cnt_a", pkt_cnt_a, 1);
        check("t3_err_end", err_timeout, 0);
        do_reset;

        // watchdog revokes a stalled grant
        req_a = 1'b1;
        req_b = 1'b1;
        data_a = 11'h021;
        data_b = 11'h031;
        #1;
        check("t4_idle_ready_b", ready_b, 0);
        step;
        #1;
        check("t4_head_write", out_write, 1);
        check("t4_head_data", out_data, 11'h021);
        step;
        req_a = 1'b0;
        for (int s = 0; s < 4; s++) begin
            #1;
            check("t4_stall_write", out_write, 0);
            check("t4_stall_ready_a", ready_a, 1);
            check("t4_stall_err", err_timeout, 0);
            step;
        end
        req_a = 1'b1;
        #1;
        check("t4_err", err_timeout, 1);
        check("t4_idle_ready_a", ready_a, 0);
        check("t4_idle_ready_b2", ready_b, 0);
        step;
        #1;
        check("t4_b_ready", ready_b, 1);
        check("t4_a_ready", ready_a, 0);
        check("t4_b_write", out_write, 1);
        check("t4_b_data", out_data, 11'h031);
        check("t4_cnt_a", pkt_cnt_a, 0);
        check("t4_err_sticky", err_timeout, 1);
        do_reset;

        // asynchronous reset in the middle of a B packet
        req_a = 1'b1;
        data_a = 11'h401;
        #1;
        step;
        req_b = 1'b1;
        data_b = 11'h041;
        #1;
        check("t5_a_tail", out_data, 11'h401);
        step;
        req_a = 1'b0;
        #1;
        check("t5_b1_data", out_data, 11'h041);
        check("t5_b1_ready", ready_b, 1);
        step;
        data_b = 11'h042;
        #1;
        check("t5_b2_data", out_data, 11'h042);
        step;
        data_b = 11'h443;
        #1;
        check("t5_b3_write", out_write, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_write", out_write, 0);
        check("t5_rst_ready_b", ready_b, 0);
        check("t5_rst_data", out_data, 0);
        check("t5_rst_cnt_a", pkt_cnt_a, 0);
        @(negedge clk);
        reset = 1'b0;
        req_a = 1'b1;
        req_b = 1'b1;
        data_a = 11'h051;
        data_b = 11'h061;
        #1;
        check("t5_idle_write", out_write, 0);
        step;
        #1;
        check("t5_prio_ready_a", ready_a, 1);
        check("t5_prio_ready_b", ready_b, 0);
        check("t5_prio_data", out_data, 11'h051);
        do_reset;

        // packet counter wrap
        req_a = 1'b1;
        data_a = 11'h400;
        #1;
        step;
        for (int i = 1; i <= 17; i++) begin
            data_a = 11'h400 | 11'(i);
            #1;
            check("t6_write", out_write, 1);
            step;
        end
        #1;
        check("t6_cnt_wrap", pkt_cnt_a, 1);
        check("t6_cnt_b", pkt_cnt_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/output_allocator.md
Name: output_allocator

Overview:
- Shares one router output between two input controllers (requesters A and B) of the same router node.
- Arbitrates round-robin on packet boundaries and holds a grant until the granted packet's tail flit has been written.
- Returns per-requester ready, and muxes the granted requester's 11-bit flits into the downstream output FIFO.
- Adds a stall watchdog and per-input packet counters.

Parameters:
- WIDTH, 11, flit width; bit WIDTH-1 is the tail flag.
- TIMEOUT, 255, consecutive cycles the granted requester may hold req low before the grant is revoked; must be 1..255.
- CNT_W, 16, width of the packet counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_a  in  1  requester A wants this output; flit on data_a is valid while req_a=1.
- data_a  in  WIDTH  flit from requester A.
- ready_a  out  1  flit on data_a is accepted this cycle when req_a=1.
- req_b  in  1  requester B wants this output; flit on data_b is valid while req_b=1.
- data_b  in  WIDTH  flit from requester B.
- ready_b  out  1  flit on data_b is accepted this cycle when req_b=1.
- out_full  in  1  downstream FIFO full.
- out_write  out  1  write strobe to downstream FIFO.
- out_data  out  WIDTH  flit to downstream FIFO.
- pkt_cnt_a  out  CNT_W  tails forwarded from A; wraps.
- pkt_cnt_b  out  CNT_W  tails forwarded from B; wraps.
- err_timeout  out  1  sticky watchdog flag.

Behaviour:
- States: IDLE, GRANT_A, GRANT_B. State register, priority pointer `prio` (0=A, 1=B), stall counter (8 bit), packet counters and err_timeout are all reset asynchronously.
- Reset values:
  - state=IDLE, prio=0, stall counter=0.
  - pkt_cnt_a=pkt_cnt_b=0, err_timeout=0.
  - ready_a=ready_b=out_write=0, out_data=0.
- Arbitration function `arb(excl)`:
  - If exactly one req is high, pick it.
  - If both are high, pick A when prio=0, else B.
  - If none is high, pick none.
  - When excl is given, the excluded requester may only win if the other requester is low.
- IDLE:
  - ready_a=ready_b=0 and out_write=0.
  - Next state = GRANT of arb(). Grant takes effect the next cycle, so there is one cycle of arbitration latency.
- GRANT_X:
  - ready_X = ~out_full; ready of the other requester = 0.
  - Transfer occurs when req_X & ready_X.
  - out_write = transfer, combinational with zero latency.
  - out_data = data_X while in GRANT_X, else 0.
- Tail transfer (data_X[WIDTH-1]=1 during a transfer):
  - Increment pkt_cnt_X, wrapping.
  - Set prio to point to the other requester.
  - Next state = GRANT of arb(excl=X) evaluated in the same cycle, or IDLE if none. Back-to-back packets have no bubble.
- Non-tail transfer, or no transfer: stay in GRANT_X.
- out_full=1 in GRANT_X:
  - ready_X=0, so no write occurs.
  - This is not a stall: the stall counter holds its value.
- Watchdog:
  - In GRANT_X, the stall counter increments each cycle with req_X=0.
  - It clears on any cycle with req_X=1 and on every state change.
  - When the counter reaches TIMEOUT: next state=IDLE, prio points to the other requester, err_timeout<=1 (sticky until reset), counter<=0. No flit is written in that cycle.
- Requester deasserting req mid-packet: grant is held (the controller may be waiting on its FIFO). Only the watchdog releases it.
- The allocator never inspects flit contents other than the tail bit, and never modifies data.
- Reset asserted mid-packet: immediately returns to IDLE with all outputs at reset values. Any partial packet already written downstream is not recalled.

Test Plan:
- Single packet:
  - Stimulus: req_a=1, flits 0x005, 0x006, 0x407 (tail), out_full=0.
  - Required response: ready_a=1 from cycle 1; three out_write pulses with matching out_data; then IDLE; pkt_cnt_a=1; ready_b stays 0 throughout.
- Simultaneous requests after reset:
  - Stimulus: req_a=req_b=1, each sending 2-flit packets continuously.
  - Required response: grant order A,B,A,B with no idle cycle between packets; pkt_cnt_a=pkt_cnt_b=2 after 8 writes.
- Backpressure:
  - Stimulus: out_full=1 for 5 cycles in the middle of an A packet.
  - Required response: ready_a=0 and out_write=0 for those 5 cycles; stream resumes with no lost or duplicated flit; err_timeout stays 0.
- Watchdog:
  - Stimulus: TIMEOUT=4; A sends a header then drops req_a for 4 cycles; req_b=1.
  - Required response: state goes to IDLE after the 4th stalled cycle; err_timeout=1; B granted next; pkt_cnt_a unchanged.
- Async reset mid-packet:
  - Stimulus: reset pulse between flits 2 and 3 of a B packet.
  - Required response: outputs go to 0 immediately; after reset A is preferred (prio=0) when both request.
- Counter wrap:
  - Stimulus: CNT_W=4; 17 single-flit tail packets from A.
  - Required response: pkt_cnt_a=1.
